trng_seed_collector: RTL and testbench

Wishbone master that drives the TRNG core's slave port (the `trng_wb_*` bus). It polls the TRNG status register and reads raw data words. Each word is health-tested: stuck or repeated words are rejected. Accepted words are XOR-folded into a 32-bit seed, which is presented with a valid flag on the `trng_i` seed input of the SRAM wrapper and LFSR. This replaces the current constant-zero seed.

---
 rtl/trng_seed_collector.sv | 178 +++++++++++++++++
 tb/tb_trng_seed_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_seed_collector.sv
// trng_seed_collector: Wishbone master that polls a TRNG, health-tests raw words
// and XOR-folds accepted words into a 32-bit seed.
module trng_seed_collector #(
    parameter logic [8:0] STATUS_ADR  = 9'h000,
    parameter logic [8:0] DATA_ADR    = 9'h004,
    parameter int         READY_BIT   = 0,
    parameter int         WORDS       = 2,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         POLL_LIMIT  = 255,
    parameter int         MAX_REJECT  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        refresh_i,
    output logic        trng_wb_cyc_o,
    output logic        trng_wb_stb_o,
    output logic [8:0]  trng_wb_adr_o,
    output logic        trng_wb_we_o,
    output logic [31:0] trng_wb_dat_o,
    input  logic [31:0] trng_wb_dat_i,
    input  logic        trng_wb_ack_i,
    output logic [31:0] seed_o,
    output logic        seed_valid_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [1:0]  error_code_o
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {START, POLL, POLL_GAP, READ, EVAL, DONE, ERROR} state_t;
    state_t        state_q, state_d;
    logic          cyc_q, cyc_d, rdy_q, rdy_d;
    logic [8:0]    adr_q, adr_d;
    logic [31:0]   sample_q, sample_d, prev_q, prev_d, acc_q, acc_d, seed_q, seed_d;
    logic          valid_q, valid_d, busy_q, busy_d, err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    poll_q, poll_d, rej_q, rej_d;
    logic [3:0]    words_q, words_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ack, expire, bad, restart;
    always_comb begin
        ack      = cyc_q & trng_wb_ack_i;
        expire   = cyc_q & ~trng_wb_ack_i & (tmo_q == TW'(ACK_TIMEOUT - 1));
        bad      = (sample_q == '0) | (&sample_q) | (sample_q == prev_q);
        restart  = refresh_i & ((state_q == DONE) | (state_q == ERROR));
        state_d  = state_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;
        rdy_d    = rdy_q;
        sample_d = sample_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        seed_d   = seed_q;
        valid_d  = valid_q;
        err_d    = err_q;
        code_d   = code_q;
        poll_d   = poll_q;
        rej_d    = rej_q;
        words_d  = words_q;
        tmo_d    = (cyc_q & ~trng_wb_ack_i) ? tmo_q + TW'(1) : '0;
        case (state_q)
            START: begin
                state_d = POLL;
                cyc_d   = 1'b1;
                adr_d   = STATUS_ADR;
            end
            POLL: if (ack) begin
                cyc_d  = 1'b0;
                rdy_d  = trng_wb_dat_i[READY_BIT];
                poll_d = rdy_d ? '0 : poll_q + 8'd1;
                if (!rdy_d && poll_d == 8'(POLL_LIMIT)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    state_d = POLL_GAP;
                end
            end
            // Every access is followed by this idle cycle; rdy_q picks the next access.
            POLL_GAP: begin
                cyc_d   = 1'b1;
                adr_d   = rdy_q ? DATA_ADR : STATUS_ADR;
                state_d = rdy_q ? READ : POLL;
            end
            READ: if (ack) begin
                cyc_d    = 1'b0;
                sample_d = trng_wb_dat_i;
                state_d  = EVAL;
            end
            EVAL: begin
                prev_d = sample_q;
                rdy_d  = 1'b0;
                if (bad && rej_q + 8'd1 == 8'(MAX_REJECT)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                end else if (bad) begin
                    rej_d   = rej_q + 8'd1;
                    state_d = POLL_GAP;
                end else begin
                    acc_d   = acc_q ^ sample_q;
                    rej_d   = '0;
                    words_d = words_q + 4'd1;
                    seed_d  = (words_d == 4'(WORDS)) ? acc_d : seed_q;
                    valid_d = words_d == 4'(WORDS);
                    state_d = (words_d == 4'(WORDS)) ? DONE : POLL_GAP;
                end
            end
            default: ;
        endcase
        if (expire) begin
            cyc_d   = 1'b0;
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = 2'b01;
        end
        if (restart) begin
            state_d = POLL;
            cyc_d   = 1'b1;
            adr_d   = STATUS_ADR;
            rdy_d   = 1'b0;
            acc_d   = '0;
            poll_d  = '0;
            rej_d   = '0;
            words_d = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end
        busy_d = (state_d == POLL) | (state_d == POLL_GAP) | (state_d == READ) | (state_d == EVAL);
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= START;
            cyc_q    <= 1'b0;
            adr_q    <= '0;
            rdy_q    <= 1'b0;
            sample_q <= '0;
            prev_q   <= '0;
            acc_q    <= '0;
            seed_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            poll_q   <= '0;
            rej_q    <= '0;
            words_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            rdy_q    <= rdy_d;
            sample_q <= sample_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            seed_q   <= seed_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            code_q   <= code_d;
            poll_q   <= poll_d;
            rej_q    <= rej_d;
            words_q  <= words_d;
            tmo_q    <= tmo_d;
        end
    end
    assign trng_wb_cyc_o = cyc_q;
    assign trng_wb_stb_o = cyc_q;
    assign trng_wb_adr_o = adr_q;
    assign trng_wb_we_o  = 1'b0;
    assign trng_wb_dat_o = '0;
    assign seed_o        = seed_q;
    assign seed_valid_o  = valid_q;
    assign busy_o        = busy_q;
    assign error_o       = err_q;
    assign error_code_o  = code_q;
endmodule

// File: tb/tb_trng_seed_collector.sv
// tb_trng_seed_collector: directed scenarios against a scripted TRNG Wishbone slave.
module tb_trng_seed_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        refresh = 1'b0;
    logic        cyc, stb, we, ack, valid, busy, err;
    logic [8:0]  adr;
    logic [31:0] dato, dati, seed;
    logic [1:0]  code;
    logic        stray = 1'b0;
    logic        we_seen = 1'b0;
    int          ack_mode = 1;
    int          n_stat = 0, n_data = 0, sb = 0, db = 0, si, di;
    logic [127:0] stat_pk = '0, data_pk = '0;
    int          total = 0, bad = 0;

    trng_seed_collector dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .refresh_i(refresh),
        .trng_wb_cyc_o(cyc), .trng_wb_stb_o(stb), .trng_wb_adr_o(adr),
        .trng_wb_we_o(we), .trng_wb_dat_o(dato), .trng_wb_dat_i(dati),
        .trng_wb_ack_i(ack), .seed_o(seed), .seed_valid_o(valid),
        .busy_o(busy), .error_o(err), .error_code_o(code)
    );

    always #5 clk = ~clk;

    always_comb begin
        si = (n_stat - sb > 3) ? 3 : n_stat - sb;
        di = (n_data - db > 3) ? 3 : n_data - db;
    end
    assign dati = (adr == 9'h000) ? stat_pk[32*si +: 32] : data_pk[32*di +: 32];
    assign ack  = stray | (cyc & stb & (ack_mode == 1 || (ack_mode == 2 && adr == 9'h000)));

    always @(posedge clk) begin
        if (cyc && ack) begin
            if (adr == 9'h000) n_stat <= n_stat + 1;
            else n_data <= n_data + 1;
        end
        if (we || dato != 32'h0) we_seen <= 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entries are {w3, w2, w1, w0}; the last entry repeats once the sequence runs out.
    task automatic load(input logic [127:0] st, input logic [127:0] dt);
        stat_pk = st;
        data_pk = dt;
        sb = n_stat;
        db = n_data;
    endtask

    task automatic pulse_refresh;
        refresh = 1'b1;
        tick;
        refresh = 1'b0;
    endtask

    task automatic test_reset;
        load({4{32'h1}}, {64'h0, 32'h0F0F0F0F, 32'h12345678});
        repeat (3) tick;
        total++;
        if ({cyc, stb, adr, seed, valid, busy, err, code} !== 48'h0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0", {cyc, stb, adr, seed, valid, busy, err, code});
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick;
            if (e == 1) begin
                total++;
                if ({cyc, stb, adr, busy} !== {1'b1, 1'b1, 9'h000, 1'b1}) begin
                    bad++;
                    $display("FAIL first_poll got %h want %h", {cyc, stb, adr, busy}, {1'b1, 1'b1, 9'h000, 1'b1});
                end
            end
            if (e == 9) begin
                total++;
                if (valid !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_early got %b want 0", valid);
                end
            end
        end
        total++;
        if ({valid, busy, seed} !== {1'b1, 1'b0, 32'h1D3B5977}) begin
            bad++;
            $display("FAIL first_seed got %b %b %h want 1 0 1d3b5977", valid, busy, seed);
        end
    endtask

    task automatic test_poll_retry;
        int reads = 0, n = 0;
        logic pc = 1'b0, dbl = 1'b0, busy_ok = 1'b1, seen_data = 1'b0;
        load({32'h1, 32'h0, 32'h0, 32'h0}, {64'h0, 32'h22222222, 32'h11111111});
        pulse_refresh;
        while (!valid && n < 100) begin
            if (cyc && adr == 9'h004) seen_data = 1'b1;
            if (cyc && !pc && adr == 9'h000 && !seen_data) reads++;
            if (cyc && pc) dbl = 1'b1;
            if (!busy) busy_ok = 1'b0;
            pc = cyc;
            tick;
            n++;
        end
        total++;
        if (reads !== 4 || dbl !== 1'b0 || busy_ok !== 1'b1) begin
            bad++;
            $display("FAIL poll_retry got reads=%0d back2back=%b busy=%b want 4 0 1", reads, dbl, busy_ok);
        end
        total++;
        if ({valid, seed} !== {1'b1, 32'h33333333}) begin
            bad++;
            $display("FAIL poll_retry_seed got %b %h want 1 33333333", valid, seed);
        end
    endtask

    task automatic test_reject;
        int n = 0;
        load({4{32'h1}}, {32'h0, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA});
        pulse_refresh;
        while (!valid && n < 100) begin
            tick;
            n++;
        end
        total++;
        if ({valid, seed} !== {1'b1, 32'hFFFFFFFF} || n_data - db !== 3) begin
            bad++;
            $display("FAIL reject_seed got %b %h reads=%0d want 1 ffffffff 3", valid, seed, n_data - db);
        end
    endtask

    task automatic test_health_error;
        int n = 0;
        load({4{32'h1}}, 128'h0);
        pulse_refresh;
        while (!err && n < 100) begin
            tick;
            n++;
        end
        total++;
        if ({err, code, cyc, busy, valid} !== {1'b1, 2'b11, 3'b000} || n_data - db !== 4) begin
            bad++;
            $display("FAIL health_error got %b %b reads=%0d want 1 11 4", err, code, n_data - db);
        end
        total++;
        if (seed !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL health_seed_kept got %h want ffffffff", seed);
        end
        stray = 1'b1;
        repeat (3) tick;
        stray = 1'b0;
        total++;
        if ({err, code, cyc} !== {1'b1, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL stray_ack got %b %b %b want 1 11 0", err, code, cyc);
        end
        load({4{32'h1}}, {64'h0, 32'h24681357, 32'h13572468});
        pulse_refresh;
        total++;
        if ({err, code, cyc, adr, busy} !== {1'b0, 2'b00, 1'b1, 9'h000, 1'b1}) begin
            bad++;
            $display("FAIL error_clear got %b %b %b %h %b want 0 00 1 000 1", err, code, cyc, adr, busy);
        end
        n = 0;
        while (!valid && n < 100) begin
            tick;
            n++;
        end
        total++;
        if ({valid, seed} !== {1'b1, 32'h373F373F}) begin
            bad++;
            $display("FAIL resume_seed got %b %h want 1 373f373f", valid, seed);
        end
    endtask

    task automatic test_poll_limit;
        int n = 0;
        load(128'h0, {4{32'h01020304}});
        pulse_refresh;
        while (!err && n < 2000) begin
            tick;
            n++;
        end
        total++;
        if ({err, code} !== {1'b1, 2'b10} || n_stat - sb !== 255 || n_data - db !== 0) begin
            bad++;
            $display("FAIL poll_limit got %b %b polls=%0d reads=%0d want 1 10 255 0", err, code, n_stat - sb, n_data - db);
        end
    endtask

    task automatic test_ack_timeout;
        int hi = 0, n = 0;
        ack_mode = 0;
        load({4{32'h1}}, {4{32'h01020304}});
        pulse_refresh;
        total++;
        if ({err, code} !== 3'b000) begin
            bad++;
            $display("FAIL refresh_clears got %b %b want 0 00", err, code);
        end
        while (cyc && n < 40) begin
            hi++;
            refresh = (hi == 5);
            tick;
            n++;
        end
        refresh = 1'b0;
        total++;
        if (hi !== 16 || {err, code, cyc, stb} !== {1'b1, 2'b01, 2'b00}) begin
            bad++;
            $display("FAIL ack_timeout got cyc_cycles=%0d %b %b want 16 1 01", hi, err, code);
        end
    endtask

    task automatic test_async_reset;
        int n = 0;
        ack_mode = 2;
        load({4{32'h1}}, {4{32'h01020304}});
        pulse_refresh;
        while (!(cyc && adr == 9'h004) && n < 20) begin
            tick;
            n++;
        end
        total++;
        if ({cyc, adr, seed} !== {1'b1, 9'h004, 32'h373F373F}) begin
            bad++;
            $display("FAIL data_read_pending got %b %h %h want 1 004 373f373f", cyc, adr, seed);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({cyc, stb, seed, valid, busy, err} !== 37'h0) begin
            bad++;
            $display("FAIL async_reset got %h want 0", {cyc, stb, seed, valid, busy, err});
        end
        tick;
        ack_mode = 1;
        load({4{32'h1}}, {64'h0, 32'h600DCAFE, 32'h0BADF00D});
        rst_n = 1'b1;
        n = 0;
        while (!valid && n < 30) begin
            tick;
            n++;
        end
        total++;
        if (n !== 10 || seed !== 32'h6BA03AF3) begin
            bad++;
            $display("FAIL restart_seed got edges=%0d %h want 10 6ba03af3", n, seed);
        end
        total++;
        if (we_seen !== 1'b0) begin
            bad++;
            $display("FAIL write_tieoff got %b want 0", we_seen);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_poll_retry;
        test_reject;
        test_health_error;
        test_poll_limit;
        test_ack_timeout;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
